// File: rtl/acx_axi_reg_bus_ctrl_if.sv
// AXI4-Lite target-side bundle for the configuration register bus controller.
// The master modport is the AXI initiator, the slave modport is the controller.
interface acx_axi_reg_bus_ctrl_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32
);
    logic                  s_awvalid;
    logic                  s_awready;
    logic [ADDR_W-1:0]     s_awaddr;

    logic                  s_wvalid;
    logic                  s_wready;
    logic [DATA_W-1:0]     s_wdata;
    logic [DATA_W/8-1:0]   s_wstrb;

    logic                  s_bvalid;
    logic                  s_bready;
    logic [1:0]            s_bresp;

    logic                  s_arvalid;
    logic                  s_arready;
    logic [ADDR_W-1:0]     s_araddr;

    logic                  s_rvalid;
    logic                  s_rready;
    logic [DATA_W-1:0]     s_rdata;
    logic [1:0]            s_rresp;

    modport master (
        output s_awvalid,
        output s_awaddr,
        output s_wvalid,
        output s_wdata,
        output s_wstrb,
        output s_bready,
        output s_arvalid,
        output s_araddr,
        output s_rready,
        input  s_awready,
        input  s_wready,
        input  s_bvalid,
        input  s_bresp,
        input  s_arready,
        input  s_rvalid,
        input  s_rdata,
        input  s_rresp
    );

    modport slave (
        input  s_awvalid,
        input  s_awaddr,
        input  s_wvalid,
        input  s_wdata,
        input  s_wstrb,
        input  s_bready,
        input  s_arvalid,
        input  s_araddr,
        input  s_rready,
        output s_awready,
        output s_wready,
        output s_bvalid,
        output s_bresp,
        output s_arready,
        output s_rvalid,
        output s_rdata,
        output s_rresp
    );
endinterface

// File: rtl/acx_axi_reg_bus_ctrl.sv
// AXI4-Lite target that serialises accesses onto the shared register bus,
// with round-robin write/read arbitration and a no-hit timeout.
module acx_axi_reg_bus_ctrl #(
    parameter int                        TGT_ADDR_WIDTH = 28,
    parameter int                        TGT_DATA_WIDTH = 32,
    parameter int                        TIMEOUT_CYCLES = 64,
    parameter logic [TGT_DATA_WIDTH-1:0] ERR_RDATA      = 32'hBADADD00
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    acx_axi_reg_bus_ctrl_if.slave         s_axi,
    output logic [TGT_DATA_WIDTH/8-1:0]   o_reg_wr,
    output logic                          o_reg_rd,
    output logic [TGT_ADDR_WIDTH-1:0]     o_reg_addr,
    output logic [TGT_DATA_WIDTH-1:0]     o_reg_wdata,
    input  logic                          i_reg_hit,
    input  logic [TGT_DATA_WIDTH-1:0]     i_reg_rdata
);

    localparam int SW    = TGT_DATA_WIDTH / 8;
    localparam int CNT_W = 10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [TGT_ADDR_WIDTH-1:0] ADDR_MASK =
        {{(TGT_ADDR_WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        WR_RESP,
        RD_RESP,
        GAP
    } state_t;

    state_t                      state_q, state_d;
    logic                        prio_rd_q, prio_rd_d;
    logic                        awready_q, awready_d;
    logic                        arready_q, arready_d;
    logic [SW-1:0]               wr_q, wr_d;
    logic                        rd_q, rd_d;
    logic [TGT_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [TGT_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic                        rvalid_q, rvalid_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic [TGT_DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                        wr_req;
    logic                        rd_req;
    logic                        hit_ok;
    logic                        tmo;

    assign wr_req = s_axi.s_awvalid && s_axi.s_wvalid;
    assign rd_req = s_axi.s_arvalid;

    // Slave decode is two stages deep: hits in the first two issue cycles are stale.
    assign hit_ok = i_reg_hit && (cnt_q >= CNT_W'(2));
    assign tmo    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        prio_rd_d = prio_rd_q;
        awready_d = 1'b0;
        arready_d = 1'b0;
        wr_d      = wr_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (awready_q) begin
                    addr_d  = s_axi.s_awaddr & ADDR_MASK;
                    wdata_d = s_axi.s_wdata;
                    cnt_d   = '0;
                    if (s_axi.s_wstrb == '0) begin
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_OKAY;
                        state_d  = WR_RESP;
                    end else begin
                        wr_d    = s_axi.s_wstrb;
                        state_d = WR_ISSUE;
                    end
                end else if (arready_q) begin
                    addr_d  = s_axi.s_araddr & ADDR_MASK;
                    rd_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = RD_ISSUE;
                end else if (wr_req && (!rd_req || !prio_rd_q)) begin
                    awready_d = 1'b1;
                    prio_rd_d = 1'b1;
                end else if (rd_req) begin
                    arready_d = 1'b1;
                    prio_rd_d = 1'b0;
                end
            end

            WR_ISSUE: begin
                if (hit_ok || tmo) begin
                    wr_d     = '0;
                    bvalid_d = 1'b1;
                    bresp_d  = hit_ok ? RESP_OKAY : RESP_SLVERR;
                    state_d  = WR_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RD_ISSUE: begin
                if (hit_ok || tmo) begin
                    rd_d     = 1'b0;
                    rvalid_d = 1'b1;
                    rresp_d  = hit_ok ? RESP_OKAY : RESP_SLVERR;
                    rdata_d  = hit_ok ? i_reg_rdata : ERR_RDATA;
                    state_d  = RD_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WR_RESP: begin
                if (s_axi.s_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = GAP;
                end
            end

            RD_RESP: begin
                if (s_axi.s_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = GAP;
                end
            end

            GAP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            prio_rd_q <= 1'b0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_rd_q <= prio_rd_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axi.s_awready = awready_q;
    assign s_axi.s_wready  = awready_q;
    assign s_axi.s_arready = arready_q;
    assign s_axi.s_bvalid  = bvalid_q;
    assign s_axi.s_bresp   = bresp_q;
    assign s_axi.s_rvalid  = rvalid_q;
    assign s_axi.s_rresp   = rresp_q;
    assign s_axi.s_rdata   = rdata_q;

    assign o_reg_wr    = wr_q;
    assign o_reg_rd    = rd_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;

endmodule

// File: tb/tb_acx_axi_reg_bus_ctrl.sv
// Bench for acx_axi_reg_bus_ctrl: transaction timelines are planned up front
// into per-cycle expectation tables and compared against the DUT every cycle.
module tb_acx_axi_reg_bus_ctrl;

    localparam int          AW   = 28;
    localparam int          T    = 64;
    localparam int          NCYC = 20000;
    localparam logic [31:0] ERR  = 32'hBADADD00;

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic [3:0]      reg_wr;
    logic            reg_rd;
    logic [AW-1:0]   reg_addr;
    logic [31:0]     reg_wdata;
    logic            reg_hit   = 1'b0;
    logic [31:0]     reg_rdata = 32'h0;

    acx_axi_reg_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    acx_axi_reg_bus_ctrl #(
        .TGT_ADDR_WIDTH (AW),
        .TGT_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (T),
        .ERR_RDATA      (ERR)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .s_axi       (bus.slave),
        .o_reg_wr    (reg_wr),
        .o_reg_rd    (reg_rd),
        .o_reg_addr  (reg_addr),
        .o_reg_wdata (reg_wdata),
        .i_reg_hit   (reg_hit),
        .i_reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected per-cycle behaviour, zero wherever nothing is planned
    bit          e_awr   [NCYC];
    bit          e_arr   [NCYC];
    bit [3:0]    e_wr    [NCYC];
    bit          e_rd    [NCYC];
    bit [AW-1:0] e_addr  [NCYC];
    bit [31:0]   e_wdata [NCYC];
    bit          e_bv    [NCYC];
    bit [1:0]    e_bresp [NCYC];
    bit          e_rv    [NCYC];
    bit [1:0]    e_rresp [NCYC];
    bit [31:0]   e_rdata [NCYC];

    int errors = 0;
    int checks = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endfunction

    // observation counters used for the literal checks
    int          mon_wr_cnt, mon_rd_cnt, mon_rv_cnt;
    int          mon_acc, mon_bv;
    logic [3:0]  mon_wr_val;
    logic [1:0]  mon_bresp, mon_rresp;
    logic [31:0] mon_rdata;
    string       gorder = "";
    bit          bv_prev = 0, rv_prev = 0;

    task automatic clr_mon();
        mon_wr_cnt = 0; mon_rd_cnt = 0; mon_rv_cnt = 0;
        mon_acc = -1; mon_bv = -1; mon_wr_val = 4'h0;
        mon_bresp = 2'bxx; mon_rresp = 2'bxx; mon_rdata = 32'hx;
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NCYC) begin
            chk("awready", 32'(bus.s_awready), 32'(e_awr[cyc]));
            chk("wready",  32'(bus.s_wready),  32'(e_awr[cyc]));
            chk("arready", 32'(bus.s_arready), 32'(e_arr[cyc]));
            chk("reg_wr",  32'(reg_wr),        32'(e_wr[cyc]));
            chk("reg_rd",  32'(reg_rd),        32'(e_rd[cyc]));
            chk("bvalid",  32'(bus.s_bvalid),  32'(e_bv[cyc]));
            chk("rvalid",  32'(bus.s_rvalid),  32'(e_rv[cyc]));
            if (e_wr[cyc] != 4'h0 || e_rd[cyc])
                chk("reg_addr", 32'(reg_addr), 32'(e_addr[cyc]));
            if (e_wr[cyc] != 4'h0)
                chk("reg_wdata", reg_wdata, e_wdata[cyc]);
            if (e_bv[cyc])
                chk("bresp", 32'(bus.s_bresp), 32'(e_bresp[cyc]));
            if (e_rv[cyc]) begin
                chk("rresp", 32'(bus.s_rresp), 32'(e_rresp[cyc]));
                chk("rdata", bus.s_rdata, e_rdata[cyc]);
            end
        end
        if (reg_wr != 4'h0) begin
            mon_wr_cnt++;
            mon_wr_val = reg_wr;
        end
        if (reg_rd === 1'b1) mon_rd_cnt++;
        if (bus.s_awready === 1'b1 && bus.s_awvalid === 1'b1) begin
            mon_acc = cyc;
            gorder = {gorder, "W"};
        end
        if (bus.s_arready === 1'b1 && bus.s_arvalid === 1'b1)
            gorder = {gorder, "R"};
        if (bus.s_bvalid === 1'b1 && !bv_prev) begin
            mon_bv = cyc;
            mon_bresp = bus.s_bresp;
        end
        if (bus.s_rvalid === 1'b1) begin
            mon_rv_cnt++;
            if (!rv_prev) begin
                mon_rresp = bus.s_rresp;
                mon_rdata = bus.s_rdata;
            end
        end
        bv_prev = (bus.s_bvalid === 1'b1);
        rv_prev = (bus.s_rvalid === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // master-side model state
    bit          pw, pr, prio_rd;
    logic [AW-1:0] pw_addr, pr_addr, nw_addr, nr_addr;
    logic [31:0] pw_data, nw_data;
    logic [3:0]  pw_strb, nw_strb;

    // One granted transaction, starting in an idle cycle.
    // d: cycles after issue at which the slave hits (<0: never);
    // stale: extra hits in the two masked cycles; roff: ready start vs first valid.
    task automatic step(input bit add_w, input bit add_r, input int d,
                        input bit stale, input int roff, input logic [31:0] hv);
        int I, A, C, H, V, R, rs;
        bit w, zs, tmo;
        if (add_w) begin
            pw = 1; pw_addr = nw_addr; pw_data = nw_data; pw_strb = nw_strb;
        end
        if (add_r) begin
            pr = 1; pr_addr = nr_addr;
        end
        bus.s_awvalid = pw; bus.s_wvalid = pw;
        bus.s_awaddr = pw_addr; bus.s_wdata = pw_data; bus.s_wstrb = pw_strb;
        bus.s_arvalid = pr; bus.s_araddr = pr_addr;
        I = cyc;
        w = pw && (!pr || !prio_rd);
        prio_rd = w;
        A = I + 1;
        C = A + 1;
        zs = w && (pw_strb == 4'h0);
        tmo = !(d >= 2 && d <= T - 1);
        if (zs) begin
            H = A;
            tmo = 0;
        end else begin
            H = tmo ? C + T - 1 : C + d;
        end
        V = H + 1;
        rs = V + roff;
        R = (rs > V) ? rs : V;
        if (w) e_awr[A] = 1; else e_arr[A] = 1;
        if (!zs) begin
            for (int k = C; k <= H; k++) begin
                e_addr[k] = w ? {pw_addr[AW-1:2], 2'b00} : {pr_addr[AW-1:2], 2'b00};
                if (w) begin
                    e_wr[k] = pw_strb;
                    e_wdata[k] = pw_data;
                end else begin
                    e_rd[k] = 1;
                end
            end
        end
        for (int k = V; k <= R; k++) begin
            if (w) begin
                e_bv[k] = 1;
                e_bresp[k] = tmo ? 2'b10 : 2'b00;
            end else begin
                e_rv[k] = 1;
                e_rresp[k] = tmo ? 2'b10 : 2'b00;
                e_rdata[k] = tmo ? ERR : hv;
            end
        end
        for (int k = I; k <= R + 1; k++) begin
            if (k == A + 1) begin
                if (w) pw = 0; else pr = 0;
                bus.s_awvalid = pw; bus.s_wvalid = pw; bus.s_arvalid = pr;
            end
            reg_hit = !zs && ((stale && (k == C || k == C + 1)) ||
                              (d >= 0 && k == C + d));
            reg_rdata = (d >= 0 && k == C + d) ? hv : $urandom;
            if (w) begin
                bus.s_bready = (k >= rs && k <= R);
                bus.s_rready = 1'($urandom);
            end else begin
                bus.s_rready = (k >= rs && k <= R);
                bus.s_bready = 1'($urandom);
            end
            tick();
        end
        reg_hit = 0;
    endtask

    // Read aborted by reset three cycles after issue.
    task automatic abort_read(input logic [AW-1:0] a);
        int I, A, C;
        I = cyc; A = I + 1; C = A + 1;
        bus.s_arvalid = 1; bus.s_araddr = a;
        bus.s_rready = 1; bus.s_bready = 1;
        e_arr[A] = 1;
        for (int k = C; k <= C + 3; k++) begin
            e_rd[k] = 1;
            e_addr[k] = {a[AW-1:2], 2'b00};
        end
        for (int k = I; k <= C + 5; k++) begin
            if (k == A + 1) bus.s_arvalid = 0;
            if (k == C + 3) rstn = 0;
            if (k == C + 4) rstn = 1;
            reg_hit = 0;
            tick();
        end
        prio_rd = 0;
    endtask

    int   d, sel, roff;
    bit   aw, ar, stl;

    initial begin
        bus.s_awvalid = 0; bus.s_awaddr = '0; bus.s_wvalid = 0;
        bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_bready = 0;
        bus.s_arvalid = 0; bus.s_araddr = '0; bus.s_rready = 0;
        pw = 0; pr = 0; prio_rd = 0;
        pw_addr = '0; pr_addr = '0; pw_data = '0; pw_strb = '0;
        clr_mon();
        repeat (3) tick();
        rstn = 1;
        tick();

        // write 0x12345678 / F @0x10, slave hits two cycles after issue
        clr_mon();
        nw_addr = 28'h10; nw_data = 32'h12345678; nw_strb = 4'hF;
        step(1, 0, 2, 0, 0, 32'h0);
        chk("t1_wr_cycles", 32'(mon_wr_cnt), 32'd3);
        chk("t1_bvalid_lat", 32'(mon_bv - mon_acc), 32'd4);
        chk("t1_bresp", 32'(mon_bresp), 32'd0);

        // read 0x10 returning 0xCAFEF00D, rready held off 5 cycles
        clr_mon();
        nr_addr = 28'h10;
        step(0, 1, 2, 0, 5, 32'hCAFEF00D);
        chk("t2_rdata", mon_rdata, 32'hCAFEF00D);
        chk("t2_rresp", 32'(mon_rresp), 32'd0);
        chk("t2_rvalid_cycles", 32'(mon_rv_cnt), 32'd6);

        // unmapped read times out
        clr_mon();
        nr_addr = 28'h7FC;
        step(0, 1, -1, 0, 0, 32'h0);
        chk("t3_rd_cycles", 32'(mon_rd_cnt), 32'd64);
        chk("t3_rresp", 32'(mon_rresp), 32'd2);
        chk("t3_rdata", mon_rdata, 32'hBADADD00);

        // stale hits in the masked cycles only
        clr_mon();
        step(0, 1, -1, 1, 1, 32'h0);
        chk("t4_stale_rresp", 32'(mon_rresp), 32'd2);
        chk("t4_stale_rd_cycles", 32'(mon_rd_cnt), 32'd64);

        // zero-strobe write, then partial strobe
        clr_mon();
        nw_addr = 28'h20; nw_data = 32'hA5A5A5A5; nw_strb = 4'h0;
        step(1, 0, 2, 0, 0, 32'h0);
        chk("t5_no_strobe", 32'(mon_wr_cnt), 32'd0);
        chk("t5_bresp", 32'(mon_bresp), 32'd0);
        clr_mon();
        nw_addr = 28'h27; nw_strb = 4'b0101;
        step(1, 0, 3, 0, 0, 32'h0);
        chk("t6_strobe_val", 32'(mon_wr_val), 32'h5);
        chk("t6_wr_cycles", 32'(mon_wr_cnt), 32'd4);

        // reset in the middle of a read
        clr_mon();
        abort_read(28'h44);
        chk("t7_rd_cycles", 32'(mon_rd_cnt), 32'd4);
        chk("t7_no_rvalid", 32'(mon_rv_cnt), 32'd0);

        // simultaneous requests right after reset alternate W,R,...
        gorder = "";
        nw_addr = 28'h100; nw_data = 32'h1; nw_strb = 4'hF; nr_addr = 28'h104;
        step(1, 1, 2, 0, 0, 32'h11);
        for (int n = 0; n < 6; n++) begin
            nw_addr = AW'(28'h200 + n * 4); nw_data = $urandom; nr_addr = AW'(28'h300 + n * 4);
            step(n % 2 == 0, n % 2 == 1, 2 + n % 3, 0, 0, $urandom);
        end
        step(0, 0, 2, 0, 0, 32'h22);
        checks++;
        if (gorder != "WRWRWRWR") begin
            errors++;
            $display("FAIL grant_order got=%s want=WRWRWRWR", gorder);
        end

        // randomized traffic
        for (int n = 0; n < 160; n++) begin
            if (!pw && !pr && ($urandom % 4 == 0))
                repeat ($urandom_range(1, 3)) tick();
            aw = !pw && ($urandom % 3 != 0);
            ar = !pr && ($urandom % 3 != 0);
            if (!pw && !pr && !aw && !ar) aw = 1;
            nw_addr = AW'($urandom);
            nw_data = $urandom;
            nw_strb = ($urandom % 5 == 0) ? 4'h0 : 4'($urandom);
            nr_addr = AW'($urandom);
            sel = int'($urandom % 10);
            d = (sel == 0) ? -1 : (sel == 1) ? int'($urandom_range(T - 2, T)) :
                int'($urandom_range(2, 6));
            stl = ($urandom % 4 == 0);
            roff = int'($urandom_range(0, 7)) - 3;
            step(aw, ar, d, stl, roff, $urandom);
        end
        while (pw || pr) step(0, 0, 2, 0, 0, $urandom);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
